// File: rtl/ins_cache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// slave = cache, master = fetch unit plus memory controller.
interface ins_cache_if;
  logic [31:0] addr_in;
  logic        hit;
  logic [31:0] ins_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_ins;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output addr_in, mem_done, mem_ins,
    input  hit, ins_out, mem_req, mem_addr,
    input  hit_cnt, miss_cnt
  );

  modport slave (
    input  addr_in, mem_done, mem_ins,
    output hit, ins_out, mem_req, mem_addr,
    output hit_cnt, miss_cnt
  );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped one-word-line instruction cache, one fill in flight.
// Ports: clk, rst (async high), rdy (global stall), bus (ins_cache_if.slave).
// Optional ICACHE_STAT_EN builds saturating hit/miss counters.
module ins_cache #(
  parameter int INDEX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  ins_cache_if.slave  bus
);
  localparam int TAG_W = 30 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [29:0]        miss_pc;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill;
  logic               unused_lo;

  assign idx       = bus.addr_in[INDEX_W+1:2];
  assign tag       = bus.addr_in[31:INDEX_W+2];
  assign unused_lo = ^bus.addr_in[1:0];

  // The fill address register doubles as the latched miss PC.
  assign miss_pc  = bus.mem_addr[31:2];
  assign fill_idx = miss_pc[INDEX_W-1:0];
  assign fill_tag = miss_pc[29:INDEX_W];

  assign bus.hit     = valid[idx] && (tag_mem[idx] == tag);
  assign bus.ins_out = data_mem[idx];

  assign fill = (state == WAIT_MEM) && rdy && bus.mem_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (!bus.hit) begin
            bus.mem_addr <= {bus.addr_in[31:2], 2'b00};
            bus.mem_req  <= 1'b1;
            state        <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_done) begin
            valid[fill_idx] <= 1'b1;
            bus.mem_req     <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_ins;
    end
  end

`ifdef ICACHE_STAT_EN
  logic start_miss;

  assign start_miss = (state == IDLE) && rdy && !bus.hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hit_cnt  <= '0;
      bus.miss_cnt <= '0;
    end else begin
      if (rdy && bus.hit && (bus.hit_cnt != '1))
        bus.hit_cnt <= bus.hit_cnt + 32'd1;
      if (start_miss && (bus.miss_cnt != '1))
        bus.miss_cnt <= bus.miss_cnt + 32'd1;
    end
  end
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule
